regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 32x32 register file.
- Adds the following to the basic 2-read / 1-write array:
  - configurable data width and depth
  - byte-enable writes
  - optional same-cycle write-to-read bypass
  - per-register busy scoreboard, so the pipelined core can detect RAW hazards on outstanding producers
- Sits between decode (reads, issue marking) and writeback (writes, busy clear).

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8
ADDR_W, 5, address width; depth = 2**ADDR_W
BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads return stored value only
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

Ports:
clk  in  1  register clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high; clears array and scoreboard
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
wbe  in  DATA_W/8  byte enables for write; bit i covers wdata[8i+7:8i]
raddr1  in  ADDR_W  read address, port 1
raddr2  in  ADDR_W  read address, port 2
rdata1  out  DATA_W  read data, port 1 (combinational)
rdata2  out  DATA_W  read data, port 2 (combinational)
busy1  out  1  register at raddr1 has an outstanding producer
busy2  out  1  register at raddr2 has an outstanding producer
issue_en  in  1  mark issue_addr busy (instruction issued that will write it)
issue_addr  in  ADDR_W  destination being issued
flush  in  1  synchronous clear of all busy bits (pipeline flush)

Behaviour:
- Reset (rst=1, asynchronous):
  - all registers <= 0 and all busy bits <= 0 immediately, without waiting for clk
  - rdata1/rdata2/busy1/busy2 read 0 while rst is high
  - reset asserted mid-write discards that write
- Write (rising clk, we=1, and not (ZERO_REG and waddr==0)):
  - for each byte i with wbe[i]=1, reg[waddr] byte i <= wdata byte i; other bytes hold
  - we=1 with wbe=0 changes no data but still clears busy
- Register 0 when ZERO_REG=1:
  - writes are ignored and reads return 0
  - issue marks are ignored; busy for addr 0 is always 0
- Read data:
  - rdataN = reg[raddrN] (combinational, zero latency)
  - when BYPASS=1, we=1, raddrN==waddr, and the address is writable: rdataN = the byte-merged value (wdata where wbe=1, stored byte elsewhere), i.e. the value the register will hold after the edge
  - both ports may read the same address; both see identical data
- Scoreboard (rising clk, priority high to low):
  1. flush=1: all busy <= 0; issue_en in the same cycle is ignored, and the writeback clear has no effect since all bits are already cleared.
  2. we=1: busy[waddr] <= 0.
  3. issue_en=1: busy[issue_addr] <= 1. When issue_addr==waddr in the same cycle, issue wins and the bit ends at 1, because the new producer supersedes the completing one.
- Busy outputs:
  - busyN = busy[raddrN], except busyN = 0 when BYPASS=1 and a write to raddrN occurs this cycle, because the data is forwarded
  - issue_en does not affect busyN until the following cycle
- No internal counters wrap. Depth is exact (2**ADDR_W entries); addresses cannot be out of range.
- Latency: write visible through the array on the cycle after the edge; with BYPASS=1, visible in the same cycle.

Decomposition:
- Package regfile_pkg:
  - default DATA_W / ADDR_W constants
  - localparam NBYTES = DATA_W/8
  - a function producing the byte-merge of stored data with wdata under wbe, shared by the write path and the bypass path
- Sub-module regfile_scoreboard:
  - 2**ADDR_W busy flip-flops
  - flush / clear / set priority logic
  - two busy read muxes
- The top level holds the data array, the byte-merge write, and the bypass muxes.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse rst between clock edges -> rdata1 for raddr1=5 reads 0x00000000 immediately, busy all 0.
- Byte write: r3=0x11223344, then we=1, wbe=4'b0101, wdata=0xAABBCCDD -> r3 reads 0x11BB33DD next cycle.
- Bypass: BYPASS=1, r7=0x0, we=1, waddr=7, wdata=0x12345678, wbe=4'hF, raddr1=raddr2=7 -> both rdata=0x12345678 in the same cycle, busy1=busy2=0. With BYPASS=0 -> both read 0x0 that cycle and 0x12345678 the next.
- Zero register: we=1, waddr=0, wdata=0xFFFFFFFF; issue_en=1, issue_addr=0 -> rdata for r0 = 0, busy1 for raddr1=0 stays 0.
- Scoreboard collision: busy[9]=1, then one edge with we=1, waddr=9 and issue_en=1, issue_addr=9 -> busy[9]=1 afterwards. Next edge with we only -> busy[9]=0.
- Flush: issue r1, r2, r31 on successive cycles (all busy), then flush=1 with issue_en=1, issue_addr=4 -> all busy bits 0 including r4; register data unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the scoreboarded register file.
//   DEF_DATA_W / DEF_ADDR_W : default register width and address width
//   NBYTES                  : byte lanes at the default width
//   merge_byte()            : one byte lane of the write merge, used for both
//                             the array write and the bypass forward value
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int NBYTES     = DEF_DATA_W / 8;

    // Byte lane of the value a register will hold after a write: the new byte
    // where the lane is enabled, the stored byte otherwise. Applied lane by
    // lane so it works for any DATA_W that is a multiple of 8.
    function automatic logic [7:0] merge_byte(
        input logic [7:0] stored,
        input logic [7:0] incoming,
        input logic       en
    );
        return en ? incoming : stored;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// One busy bit per register, marking destinations with an outstanding
// producer. Update priority on each rising edge: flush clears everything,
// then a writeback clears its bit, then an issue sets its bit (so an issue
// to the register being written back leaves it busy).
// Ports:
//   clk, rst              : clock, async active-high reset (clears all bits)
//   we, waddr             : writeback completing to waddr
//   issue_en, issue_addr  : new producer issued for issue_addr
//   flush                 : synchronous clear of all busy bits
//   raddr1/2, busy1/2     : combinational busy lookup for the two read ports
module regfile_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              busy1,
    output logic              busy2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy;
    logic             set_ok;
    logic             fwd1;
    logic             fwd2;

    // Register 0 is never a real destination when it is hardwired to zero.
    always_comb begin
        set_ok = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            if (we) begin
                busy[waddr] <= 1'b0;
            end
            // Later assignment wins: the new producer supersedes the one
            // completing in this cycle.
            if (set_ok) begin
                busy[issue_addr] <= 1'b1;
            end
        end
    end

    // A write to the read address this cycle is forwarded by the data path,
    // so the consumer need not stall on it.
    always_comb begin
        fwd1 = (BYPASS != 0) && we && (raddr1 == waddr);
        fwd2 = (BYPASS != 0) && we && (raddr2 == waddr);
    end

    always_comb begin
        busy1 = busy[raddr1] && !fwd1;
        busy2 = busy[raddr2] && !fwd2;
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
// Parametrised 2-read / 1-write register file with byte-enable writes,
// optional same-cycle write-to-read bypass, and a per-register busy
// scoreboard for RAW hazard detection.
// Ports:
//   clk, rst                 : clock, async active-high reset (array + busy)
//   we, waddr, wdata, wbe    : byte-enabled write port (also clears busy)
//   raddr1/2, rdata1/2       : combinational read ports
//   busy1/2                  : outstanding-producer flags for raddr1/2
//   issue_en, issue_addr     : mark a destination busy
//   flush                    : clear all busy bits
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic [ADDR_W-1:0]   raddr1,
    input  logic [ADDR_W-1:0]   raddr2,
    output logic [DATA_W-1:0]   rdata1,
    output logic [DATA_W-1:0]   rdata2,
    output logic                busy1,
    output logic                busy2,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_addr,
    input  logic                flush
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wmerge;
    logic              wr_ok;
    logic [ADDR_W-1:0] raddr_p [2];
    logic [DATA_W-1:0] rdata_p [2];

    always_comb begin
        wr_ok = we && !((ZERO_REG != 0) && (waddr == '0));
    end

    // Post-write value of the target register; the same value feeds the
    // array and the bypass path so the two can never disagree.
    for (genvar b = 0; b < NB; b++) begin : g_merge
        assign wmerge[8*b +: 8] = merge_byte(mem[waddr][8*b +: 8], wdata[8*b +: 8], wbe[b]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[waddr] <= wmerge;
        end
    end

    assign raddr_p[0] = raddr1;
    assign raddr_p[1] = raddr2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rdata_p[p] = mem[raddr_p[p]];
            if ((ZERO_REG != 0) && (raddr_p[p] == '0)) begin
                rdata_p[p] = '0;
            end
            if ((BYPASS != 0) && wr_ok && (raddr_p[p] == waddr)) begin
                rdata_p[p] = wmerge;
            end
            // The array is already cleared during reset, but the bypass path
            // would otherwise still forward wdata.
            if (rst) begin
                rdata_p[p] = '0;
            end
        end
    end

    assign rdata1 = rdata_p[0];
    assign rdata2 = rdata_p[1];

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .flush      (flush),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .busy1      (busy1),
        .busy2      (busy2)
    );

endmodule
